cache_fill_fsm: RTL

- Miss handler for the unified L1 cache (128 sets × 8 sixteen-bit words per block).
- On a miss it latches the address and issues 8 word reads to main memory. It then streams the returned words into the data array.
- Drives the set index and word index that the 7→128 and 3→8 one-hot decoders consume, then writes the tag.
- Sits between the cache lookup logic and the multicycle memory model.

---
 rtl/cache_fill_fsm_pkg.sv | 23 ++
 rtl/cache_fill_fsm_fill_word_counter.sv | 46 ++++
 rtl/cache_fill_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg
//   Definitions shared by the L1 cache miss-fill logic: the fill state
//   encoding, the block geometry, and the bit positions of the address fields.
//   Address layout (16-bit byte address):
//     [15:11] tag, [10:4] set index, [3:1] word offset, [0] byte (always 0).
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    localparam int unsigned WORDS_PER_BLOCK = 8;

    localparam int unsigned OFFSET_LSB = 1;
    localparam int unsigned OFFSET_MSB = 3;
    localparam int unsigned INDEX_LSB  = 4;
    localparam int unsigned INDEX_MSB  = 10;
    localparam int unsigned TAG_LSB    = 11;
    localparam int unsigned TAG_MSB    = 15;

endpackage

// File: rtl/cache_fill_fsm_fill_word_counter.sv
// fill_word_counter
//   Counts the words of one block transfer (used once for requests and once
//   for returns). The count is WORD_BITS+1 wide and saturates at
//   2**WORD_BITS. Any surplus enable is absorbed, so the count never wraps
//   into what would look like a new fill. The word index is the count
//   rotated by a start offset latched on clear. With a zero offset the index
//   equals the count.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     i_clear    restart at zero and latch i_start
//     i_en       advance by one word
//     i_start    word offset of the first transfer
//     o_word     current word index, (start + count) mod 2**WORD_BITS
//     o_last     count is at the final word (2**WORD_BITS - 1)
module fill_word_counter #(
    parameter int unsigned WORD_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [WORD_BITS-1:0] i_start,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_last
);

    logic [WORD_BITS:0]   r_count;
    logic [WORD_BITS-1:0] r_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_start <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_start <= i_start;
        end else if (i_en && !r_count[WORD_BITS]) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Carry out of the add is dropped: the index wraps mod 2**WORD_BITS.
    assign o_word = r_start + r_count[WORD_BITS-1:0];
    assign o_last = (r_count == {1'b0, {WORD_BITS{1'b1}}});

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   L1 miss handler. On a miss it latches the block base, issues one word
//   read per cycle for the 8 words of the block, and writes each returned
//   word into the data array. On the 8th return it writes the tag and goes
//   back to idle.
//   Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN: the requests and
//   writes start at the missed word and wrap mod 8. Without it they run 0..7.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     miss_detected       lookup missed (ignored while busy)
//     miss_address        byte address of the missing access
//     memory_data(_valid) in-order read returns from memory
//     fsm_busy            fill in progress (pipeline stall)
//     memory_read         read request strobe
//     memory_address      request address {base, word, 1'b0}
//     set_id              latched set index for the 7->128 decoder
//     word_id             word being written, for the 3->8 decoder
//     write_data_array    write fill_data into [set_id][word_id]
//     write_tag_array     write latched tag + valid into set_id
//     fill_data           pass-through of memory_data
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SET_BITS  = 7,
    parameter int unsigned WORD_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_detected,
    input  logic [ADDR_W-1:0]    miss_address,
    input  logic [DATA_W-1:0]    memory_data,
    input  logic                 memory_data_valid,
    output logic                 fsm_busy,
    output logic                 memory_read,
    output logic [ADDR_W-1:0]    memory_address,
    output logic [SET_BITS-1:0]  set_id,
    output logic [WORD_BITS-1:0] word_id,
    output logic                 write_data_array,
    output logic                 write_tag_array,
    output logic [DATA_W-1:0]    fill_data
);

    localparam int unsigned BASE_W = ADDR_W - WORD_BITS - 1;

    fill_state_t r_state;
    fill_state_t w_next;

    logic [BASE_W-1:0]    r_base;
    logic                 w_clear;
    logic                 w_req_en;
    logic                 w_rx_en;
    logic [WORD_BITS-1:0] w_start;
    logic [WORD_BITS-1:0] w_req_word;
    logic [WORD_BITS-1:0] w_rx_word;
    logic                 w_req_last;
    logic                 w_rx_last;
    logic                 w_unused_addr;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign w_start = miss_address[OFFSET_MSB:OFFSET_LSB];
`else
    assign w_start = '0;
`endif

    // Byte bit and (in the default build) the word offset are not needed.
    assign w_unused_addr = ^miss_address[OFFSET_MSB:0];

    fill_word_counter #(.WORD_BITS(WORD_BITS)) u_req_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_en    (w_req_en),
        .i_start (w_start),
        .o_word  (w_req_word),
        .o_last  (w_req_last)
    );

    fill_word_counter #(.WORD_BITS(WORD_BITS)) u_rx_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_en    (w_rx_en),
        .i_start (w_start),
        .o_word  (w_rx_word),
        .o_last  (w_rx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_base <= miss_address[ADDR_W-1:WORD_BITS+1];
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_clear          = 1'b0;
        w_req_en         = 1'b0;
        w_rx_en          = 1'b0;
        memory_read      = 1'b0;
        memory_address   = '0;
        word_id          = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (r_state)
            IDLE: begin
                if (miss_detected) begin
                    w_clear = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                memory_read    = 1'b1;
                memory_address = {r_base, w_req_word, 1'b0};
                w_req_en       = 1'b1;
                word_id        = w_rx_word;
                // The 8th return cannot arrive before the 8th request has
                // gone out, so completion is only handled in DRAIN.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    w_rx_en          = 1'b1;
                end
                if (w_req_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                word_id = w_rx_word;
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    w_rx_en          = 1'b1;
                    if (w_rx_last) begin
                        write_tag_array = 1'b1;
                        w_next          = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign fsm_busy  = (r_state != IDLE);
    assign set_id    = r_base[SET_BITS-1:0];
    assign fill_data = memory_data;

endmodule
